// File: rtl/la_demux3_reg.sv
// One-entry registered 1-to-3 demux: a single held word is presented on the
// channel named by its one-hot select and released when that channel is ready.
module la_demux3_reg #(
  parameter int WIDTH = 8,
  parameter     PROP  = "DEFAULT"
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  input  logic             err_clear
);

  logic             full, full_nxt;
  logic [2:0]       sel_q, sel_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic             err_nxt;
  logic             pop, accept, legal;
  logic             unused_prop;

  // PROP is a tag for implementation flows only.
  assign unused_prop = ^PROP;

  assign legal     = (in_sel != 3'b000) && ((in_sel & (in_sel - 3'd1)) == 3'b000);
  // Only the selected channel's ready matters; others are masked off.
  assign pop       = full & |(sel_q & out_ready);
  assign in_ready  = ~full | pop;
  assign accept    = in_valid & in_ready;

  assign out_valid = full ? sel_q : 3'b000;
  assign out_data  = data_q;

  always_comb begin
    full_nxt = full;
    sel_nxt  = sel_q;
    data_nxt = data_q;
    err_nxt  = err;
    if (pop) full_nxt = 1'b0;
    if (accept && legal) begin
      full_nxt = 1'b1;
      sel_nxt  = in_sel;
      data_nxt = in_data;
    end
    // Illegal words are swallowed; the set beats a same-cycle clear.
    if (err_clear) err_nxt = 1'b0;
    if (accept && !legal) err_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      full   <= 1'b0;
      sel_q  <= 3'b000;
      data_q <= '0;
      err    <= 1'b0;
    end else begin
      full   <= full_nxt;
      sel_q  <= sel_nxt;
      data_q <= data_nxt;
      err    <= err_nxt;
    end
  end

endmodule
